// File: rtl/led_bank_pkg.sv
// LED bank shared definitions: channel mode encoding.
package led_bank_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t LED_OFF   = 2'b00;
   localparam mode_t LED_ON    = 2'b01;
   localparam mode_t LED_BLINK = 2'b10;
   localparam mode_t LED_PULSE = 2'b11;

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler plus shared blink counter and phase for the LED bank.
module led_tick_gen #(
   parameter int PRESCALE    = 4,
   parameter int BLINK_TICKS = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick,
   output logic blink_phase
);

   localparam int PW = $clog2(PRESCALE);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_TICKS - 1);

   logic [PW-1:0] pre_cnt;
   logic [BW-1:0] blink_cnt;

   // pre_cnt is 0 in reset, so tick is low while rst_n is asserted
   assign tick = (pre_cnt == PRE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
         if (tick) begin
            if (blink_cnt == BLK_MAX) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/led_bank_ctrl.sv
// LED bank: per-channel OFF/ON/BLINK/PULSE modes with registered drive.
module led_bank_ctrl
   import led_bank_pkg::*;
#(
   parameter int NUM_LEDS    = 5,
   parameter int PRESCALE    = 4,
   parameter int BLINK_TICKS = 2,
   parameter int PULSE_TICKS = 8,
   parameter int SEL_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [SEL_W-1:0]    wr_sel,
   input  logic [1:0]          wr_mode,
   input  logic [NUM_LEDS-1:0] trig,
   output logic [NUM_LEDS-1:0] led,
   output logic [NUM_LEDS-1:0] pulse_busy,
   output logic                tick
);

   localparam int PCW = $clog2(PULSE_TICKS + 1);

   logic                blink_phase;
   logic [NUM_LEDS-1:0] led_d;
   logic [NUM_LEDS-1:0] busy_d;

   led_tick_gen #(
      .PRESCALE   (PRESCALE),
      .BLINK_TICKS(BLINK_TICKS)
   ) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .blink_phase(blink_phase)
   );

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      mode_t          mode;
      mode_t          mode_nx;
      logic [PCW-1:0] pcnt;
      logic [PCW-1:0] pcnt_nx;
      logic           sel;
      logic           lit;

      // out-of-range selects match no channel and are dropped
      assign sel = wr_en && (wr_sel == SEL_W'(i));

      always_comb begin
         mode_nx = sel ? mode_t'(wr_mode) : mode;
         pcnt_nx = pcnt;
         if (sel && (mode_t'(wr_mode) != LED_PULSE)) begin
            pcnt_nx = '0;
         end else if (mode_nx == LED_PULSE) begin
            if (trig[i]) begin
               pcnt_nx = PCW'(PULSE_TICKS);
            end else if (tick && (pcnt != '0)) begin
               pcnt_nx = pcnt - PCW'(1);
            end
         end
      end

      always_comb begin
         lit = 1'b0;
         case (mode)
            LED_OFF:   lit = 1'b0;
            LED_ON:    lit = 1'b1;
            LED_BLINK: lit = blink_phase;
            LED_PULSE: lit = (pcnt != '0);
            default:   lit = 1'b0;
         endcase
      end

      assign led_d[i]  = lit;
      assign busy_d[i] = (pcnt != '0);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mode <= LED_OFF;
            pcnt <= '0;
         end else begin
            mode <= mode_nx;
            pcnt <= pcnt_nx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led        <= '0;
         pulse_busy <= '0;
      end else begin
         led        <= led_d;
         pulse_busy <= busy_d;
      end
   end

endmodule
